// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected input-buffer sequencer.
package fc_pkg;

    typedef enum logic [2:0] {
        LOAD,
        ISSUE,
        WAIT,
        SHIFT,
        DONE
    } fc_ibuf_state_t;

    // $clog2 that never returns 0, so a single-entry range still gets a 1-bit port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrap_cnt.sv
// Up-counter that wraps from MAX to 0, with synchronous clear and terminal-count flag.
module wrap_cnt
    import fc_pkg::*;
#(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: next-state starts from the held value so every path assigns it and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == MAX_V);

endmodule

// File: rtl/fc_ibuf_ctrl.sv
// Sequencer for the FC input buffer: loads FIFO_LENGTH beats, then walks every
// bit plane and address, handshaking one crossbar compute per address.
module fc_ibuf_ctrl
    import fc_pkg::*;
#(
    parameter int DATA_SIZE   = 8,
    parameter int FIFO_LENGTH = 8,
    parameter int NUM_ADDR    = 16,
    parameter int ADDR_W      = clog2_min1(NUM_ADDR)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_we,
    output logic                        o_se,
    output logic [ADDR_W-1:0]           o_ibuf_addr,
    output logic                        o_xbar_start,
    input  logic                        i_xbar_done,
    output logic [$clog2(DATA_SIZE):0]  o_bit_idx,
    output logic                        o_last_bit,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int LOAD_W = clog2_min1(FIFO_LENGTH);
    localparam int BIT_W  = $clog2(DATA_SIZE) + 1;

    fc_ibuf_state_t state_q;
    logic           ready_q;
    logic           busy_q;
    logic           start_q;
    logic           se_q;
    logic           done_q;

    logic              we;
    logic              load_tc;
    logic              addr_tc;
    logic              bit_tc;
    logic [LOAD_W-1:0] load_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              unused_load_cnt;

    assign we = i_valid & ready_q;

    // Counters advance on the same conditions the FSM uses to leave a state.
    wrap_cnt #(.W(LOAD_W), .MAX(FIFO_LENGTH - 1)) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (we),
        .clr_i (1'b0),
        .cnt_o (load_cnt),
        .tc_o  (load_tc)
    );

    wrap_cnt #(.W(ADDR_W), .MAX(NUM_ADDR - 1)) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i ((state_q == WAIT) & i_xbar_done),
        .clr_i (1'b0),
        .cnt_o (addr_cnt),
        .tc_o  (addr_tc)
    );

    wrap_cnt #(.W(BIT_W), .MAX(DATA_SIZE - 1)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (state_q == SHIFT),
        .clr_i (state_q == DONE),
        .cnt_o (bit_cnt),
        .tc_o  (bit_tc)
    );

    // Only the terminal flag of the load counter matters; its value is not exported.
    assign unused_load_cnt = ^load_cnt;

    // Pulse outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            se_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            se_q    <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (we && load_tc) begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (i_xbar_done) begin
                        if (!addr_tc) begin
                            state_q <= ISSUE;
                            start_q <= 1'b1;
                        end else if (!bit_tc) begin
                            state_q <= SHIFT;
                            se_q    <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    state_q <= ISSUE;
                    start_q <= 1'b1;
                end
                DONE: begin
                    state_q <= LOAD;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= LOAD;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready      = ready_q;
    assign o_we         = we;
    assign o_se         = se_q;
    assign o_ibuf_addr  = addr_cnt;
    assign o_xbar_start = start_q;
    assign o_bit_idx    = bit_cnt;
    assign o_last_bit   = bit_tc;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_fc_ibuf_ctrl.sv
// Self-checking bench for fc_ibuf_ctrl: transaction-level expectations per layer pass,
// randomized beat gaps and crossbar latency, plus a 1/1/1 corner instance.
module tb_fc_ibuf_ctrl;

    localparam int DS = 8;
    localparam int FL = 8;
    localparam int NA = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, xdone;
    logic       ready, we, se, start, last_bit, busy, done;
    logic [3:0] addr;
    logic [3:0] bit_idx;

    logic       c_valid, c_xdone;
    logic       c_ready, c_we, c_se, c_start, c_last_bit, c_busy, c_done;
    logic [0:0] c_addr;
    logic [0:0] c_bit_idx;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int n_start = 0, n_se = 0, n_done = 0, n_we = 0, n_overlap = 0;

    always #5 clk = ~clk;

    fc_ibuf_ctrl #(.DATA_SIZE(DS), .FIFO_LENGTH(FL), .NUM_ADDR(NA)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (valid),
        .o_ready      (ready),
        .o_we         (we),
        .o_se         (se),
        .o_ibuf_addr  (addr),
        .o_xbar_start (start),
        .i_xbar_done  (xdone),
        .o_bit_idx    (bit_idx),
        .o_last_bit   (last_bit),
        .o_busy       (busy),
        .o_done       (done)
    );

    fc_ibuf_ctrl #(.DATA_SIZE(1), .FIFO_LENGTH(1), .NUM_ADDR(1)) dut_c (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (c_valid),
        .o_ready      (c_ready),
        .o_we         (c_we),
        .o_se         (c_se),
        .o_ibuf_addr  (c_addr),
        .o_xbar_start (c_start),
        .i_xbar_done  (c_xdone),
        .o_bit_idx    (c_bit_idx),
        .o_last_bit   (c_last_bit),
        .o_busy       (c_busy),
        .o_done       (c_done)
    );

    // Event counters sampled mid-cycle on the main instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (start) n_start++;
            if (se) n_se++;
            if (done) n_done++;
            if (we) n_we++;
            if (we && se) n_overlap++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    // One layer pass. gap_mode: 0 continuous, 1 alternating, 2 random.
    // abort_at: flat index bit*NA+addr at which reset is asserted, or -1.
    task automatic run_layer(input int gap_mode, input int lat_lo, input int lat_hi,
                             input bit spurious, input int abort_at);
        int beats = 0;
        int k = 0;
        int first = -1;
        int lat;
        int s0 = n_start, se0 = n_se, d0 = n_done, w0 = n_we, o0 = n_overlap;

        while (beats < FL) begin
            case (gap_mode)
                0:       valid = 1'b1;
                1:       valid = (k % 2 == 0);
                default: valid = (k > 200) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            xdone = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            check("load_we", we, valid);
            check("load_ready", ready, 1);
            check("load_busy", busy, 0);
            check("load_start", start, 0);
            check("load_addr", addr, 0);
            check("load_bit", bit_idx, 0);
            if (valid) begin
                if (first < 0) first = cyc_cnt;
                beats++;
            end
            k++;
            cyc();
        end
        valid = 1'b0;
        xdone = 1'b0;

        for (int b = 0; b < DS; b++) begin
            for (int a = 0; a < NA; a++) begin
                if (b * NA + a == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check("abort_start", start, 0);
                    check("abort_busy", busy, 0);
                    check("abort_ready", ready, 0);
                    check("abort_addr", addr, 0);
                    check("abort_bit", bit_idx, 0);
                    cyc();
                    rst_n = 1'b1;
                    cyc();
                    check("abort_post_ready", ready, 1);
                    check("abort_post_bit", bit_idx, 0);
                    check("abort_post_busy", busy, 0);
                    return;
                end
                check("issue_start", start, 1);
                check("issue_addr", addr, a);
                check("issue_bit", bit_idx, b);
                check("issue_last_bit", last_bit, (b == DS - 1));
                check("issue_busy", busy, 1);
                check("issue_ready", ready, 0);
                check("issue_se", se, 0);
                if (spurious) xdone = 1'b1;
                lat = $urandom_range(lat_lo, lat_hi);
                for (int i = 1; i <= lat; i++) begin
                    cyc();
                    xdone = (i == lat);
                    check("wait_start", start, 0);
                    check("wait_addr", addr, a);
                    check("wait_se", se, 0);
                end
                cyc();
                xdone = 1'b0;
                if (a == NA - 1) begin
                    if (b < DS - 1) begin
                        check("shift_se", se, 1);
                        check("shift_addr", addr, 0);
                        check("shift_bit", bit_idx, b);
                        check("shift_done", done, 0);
                        cyc();
                    end else begin
                        check("done_pulse", done, 1);
                        check("done_se", se, 0);
                        check("done_addr", addr, 0);
                        check("done_busy", busy, 1);
                        if (gap_mode == 0 && lat_lo == lat_hi)
                            check("layer_cycles", cyc_cnt - first + 1,
                                  FL + DS * NA * (1 + lat_lo) + (DS - 1) + 1);
                        cyc();
                        check("post_done", done, 0);
                        check("post_ready", ready, 1);
                        check("post_busy", busy, 0);
                        check("post_bit", bit_idx, 0);
                    end
                end
            end
        end
        check("cnt_start", n_start - s0, DS * NA);
        check("cnt_se", n_se - se0, DS - 1);
        check("cnt_done", n_done - d0, 1);
        check("cnt_we", n_we - w0, FL);
        check("we_se_overlap", n_overlap - o0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        valid   = 1'b1;
        xdone   = 1'b0;
        c_valid = 1'b1;
        c_xdone = 1'b0;
        repeat (3) cyc();
        check("rst_we", we, 0);
        check("rst_ready", ready, 0);
        check("rst_start", start, 0);
        check("rst_se", se, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", addr, 0);
        check("rst_bit", bit_idx, 0);
        check("rst_c_we", c_we, 0);

        rst_n = 1'b1;
        #1;
        check("release_we_same_cycle", we, 0);
        cyc();
        check("release_ready", ready, 1);
        check("release_we", we, 1);
        valid = 1'b0;
        #1;
        check("release_we_drop", we, 0);

        // Corner instance: one beat, one start, no shift.
        #1;
        check("c_we", c_we, 1);
        cyc();
        c_valid = 1'b0;
        check("c_start", c_start, 1);
        check("c_addr", c_addr, 0);
        check("c_bit", c_bit_idx, 0);
        check("c_last_bit", c_last_bit, 1);
        check("c_ready", c_ready, 0);
        cyc();
        check("c_wait_start", c_start, 0);
        c_xdone = 1'b1;
        cyc();
        c_xdone = 1'b0;
        check("c_done", c_done, 1);
        check("c_se", c_se, 0);
        check("c_done_addr", c_addr, 0);
        cyc();
        check("c_post_done", c_done, 0);
        check("c_post_ready", c_ready, 1);
        check("c_post_busy", c_busy, 0);

        run_layer(1, 1, 4, 1'b1, -1);
        run_layer(0, 2, 2, 1'b0, -1);
        run_layer(2, 1, 3, 1'b1, 3 * NA + 9);
        run_layer(0, 1, 5, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
